// File: rtl/melody_sequencer.sv
// Nyan Cat melody sequencer: steps a 25-entry note table on beat ticks and
// drives a gated phase-increment command into the shared tone datapath.
module melody_sequencer #(
    parameter int TICK_SAMPLES = 5468,
    parameter int SHORT_TICKS  = 3,
    parameter int LONG_TICKS   = 7,
    parameter int SPACE_TICKS  = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       sample_strobe,
    input  logic       run,
    input  logic       restart,
    output logic       gate,
    output logic [6:0] note_inc,
    output logic [4:0] melody_pos,
    output logic       loop_done
);
    localparam int SW    = (TICK_SAMPLES > 1) ? $clog2(TICK_SAMPLES) : 1;
    localparam int MAXNS = (LONG_TICKS > SHORT_TICKS) ? LONG_TICKS : SHORT_TICKS;
    localparam int MAXT  = (MAXNS > SPACE_TICKS) ? MAXNS : SPACE_TICKS;
    localparam int TW    = (MAXT > 1) ? $clog2(MAXT) : 1;

    localparam logic [SW-1:0] SAMP_LAST  = SW'(TICK_SAMPLES - 1);
    localparam logic [TW-1:0] SHORT_LAST = TW'(SHORT_TICKS - 1);
    localparam logic [TW-1:0] LONG_LAST  = TW'(LONG_TICKS - 1);
    localparam logic [TW-1:0] SPACE_LAST = TW'(SPACE_TICKS - 1);
    localparam logic [4:0]    LAST_POS   = 5'd24;

    localparam logic [6:0] INC_GS = 7'd67;
    localparam logic [6:0] INC_FS = 7'd60;
    localparam logic [6:0] INC_DS = 7'd50;
    localparam logic [6:0] INC_D  = 7'd48;
    localparam logic [6:0] INC_CS = 7'd45;
    localparam logic [6:0] INC_B  = 7'd40;

    typedef enum logic [1:0] {IDLE, NOTE, GAP} state_t;

    state_t          state;
    logic [SW-1:0]   samp_cnt;
    logic [TW-1:0]   tick_cnt;

    function automatic logic [6:0] inc_of(input logic [4:0] idx);
        case (idx)
            5'd0, 5'd16, 5'd19:                              inc_of = INC_FS;
            5'd1, 5'd17:                                     inc_of = INC_GS;
            5'd3, 5'd15, 5'd18:                              inc_of = INC_DS;
            5'd2, 5'd5, 5'd10, 5'd11, 5'd21:                 inc_of = INC_D;
            5'd6, 5'd9, 5'd12, 5'd14, 5'd20, 5'd23:          inc_of = INC_CS;
            5'd4, 5'd7, 5'd8, 5'd13, 5'd22, 5'd24:           inc_of = INC_B;
            default:                                         inc_of = 7'd0;
        endcase
    endfunction

    function automatic logic is_long(input logic [4:0] idx);
        case (idx)
            5'd0, 5'd1, 5'd3, 5'd7, 5'd8, 5'd9, 5'd10: is_long = 1'b1;
            default:                                   is_long = 1'b0;
        endcase
    endfunction

    logic          tick;
    logic [TW-1:0] note_last;
    logic [4:0]    next_pos;

    assign tick      = sample_strobe && (samp_cnt == SAMP_LAST);
    assign note_last = is_long(melody_pos) ? LONG_LAST : SHORT_LAST;
    assign next_pos  = (melody_pos == LAST_POS) ? 5'd0 : melody_pos + 5'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            samp_cnt   <= '0;
            tick_cnt   <= '0;
            gate       <= 1'b0;
            note_inc   <= 7'd0;
            melody_pos <= 5'd0;
            loop_done  <= 1'b0;
        end else begin
            loop_done <= 1'b0;
            if (restart) begin
                melody_pos <= 5'd0;
                samp_cnt   <= '0;
                tick_cnt   <= '0;
                if (run) begin
                    state    <= NOTE;
                    gate     <= 1'b1;
                    note_inc <= inc_of(5'd0);
                end else begin
                    state <= IDLE;
                    gate  <= 1'b0;
                end
            end else if (!run) begin
                // pause holds position; the entry replays from its start on resume
                state    <= IDLE;
                gate     <= 1'b0;
                samp_cnt <= '0;
                tick_cnt <= '0;
            end else begin
                case (state)
                    IDLE: begin
                        state    <= NOTE;
                        gate     <= 1'b1;
                        note_inc <= inc_of(melody_pos);
                        samp_cnt <= '0;
                        tick_cnt <= '0;
                    end
                    NOTE, GAP: begin
                        if (sample_strobe)
                            samp_cnt <= tick ? '0 : samp_cnt + SW'(1);
                        if (tick) begin
                            if (state == NOTE && tick_cnt == note_last) begin
                                state    <= GAP;
                                gate     <= 1'b0;
                                tick_cnt <= '0;
                            end else if (state == GAP && tick_cnt == SPACE_LAST) begin
                                state      <= NOTE;
                                gate       <= 1'b1;
                                tick_cnt   <= '0;
                                melody_pos <= next_pos;
                                note_inc   <= inc_of(next_pos);
                                loop_done  <= (melody_pos == LAST_POS);
                            end else begin
                                tick_cnt <= tick_cnt + TW'(1);
                            end
                        end
                    end
                    default: begin
                        state <= IDLE;
                        gate  <= 1'b0;
                    end
                endcase
            end
        end
    end
endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer with 4-sample ticks and a strobe every cycle.
module tb_melody_sequencer;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       sample_strobe;
    logic       run;
    logic       restart;
    logic       gate;
    logic [6:0] note_inc;
    logic [4:0] melody_pos;
    logic       loop_done;

    int checks   = 0;
    int failures = 0;

    melody_sequencer #(.TICK_SAMPLES(4)) dut (
        .clk(clk), .rst_n(rst_n), .sample_strobe(sample_strobe), .run(run),
        .restart(restart), .gate(gate), .note_inc(note_inc),
        .melody_pos(melody_pos), .loop_done(loop_done)
    );

    always #5 clk = ~clk;

    typedef struct {
        int inc;
        int pos;
        int hi;
        int lo;
    } exp_t;

    int inc_tab [25] = '{60, 67, 48, 50, 40, 48, 45, 40, 40, 45, 48, 48, 45,
                         40, 45, 50, 60, 67, 50, 60, 45, 48, 40, 45, 40};
    bit long_tab[25] = '{1, 1, 0, 1, 0, 0, 0, 1, 1, 1, 1, 0, 0,
                         0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    exp_t sb[$];
    exp_t cur;
    bit   cur_valid = 0;
    bit   mon_en    = 0;
    bit   prev_gate = 0;
    int   hi_cnt = 0, lo_cnt = 0;
    int   ld_cnt = 0;
    int   cyc    = 0;

    function automatic exp_t mk(input int idx);
        exp_t e;
        e.inc = inc_tab[idx];
        e.pos = idx;
        e.hi  = (long_tab[idx] ? 7 : 3) * 4;
        e.lo  = 4;
        return e;
    endfunction

    always @(posedge clk) cyc++;

    // Pops the expected entry on each gate rise and checks note and gate/gap lengths.
    always @(negedge clk) begin
        if (loop_done === 1'b1) ld_cnt++;
        if (!mon_en) begin
            cur_valid = 0;
        end else if (gate && !prev_gate) begin
            if (cur_valid) begin
                checks++;
                if (lo_cnt !== cur.lo) begin
                    failures++;
                    $display("FAIL gap_len pos=%0d: got %0d required %0d", cur.pos, lo_cnt, cur.lo);
                end
            end
            if (sb.size() > 0) begin
                cur = sb.pop_front();
                cur_valid = 1;
                hi_cnt = 1;
                checks++;
                if (note_inc !== 7'(cur.inc) || melody_pos !== 5'(cur.pos)) begin
                    failures++;
                    $display("FAIL note_start: got inc=%0d pos=%0d required inc=%0d pos=%0d",
                             note_inc, melody_pos, cur.inc, cur.pos);
                end
            end else begin
                cur_valid = 0;
            end
        end else if (gate) begin
            hi_cnt++;
        end else if (prev_gate) begin
            if (cur_valid) begin
                checks++;
                if (hi_cnt !== cur.hi) begin
                    failures++;
                    $display("FAIL gate_len pos=%0d: got %0d required %0d", cur.pos, hi_cnt, cur.hi);
                end
            end
            lo_cnt = 1;
        end else begin
            lo_cnt++;
        end
        prev_gate = gate;
    end

    task automatic drain(input string name);
        int t = 0;
        while (sb.size() != 0 && t < 2000) begin
            @(negedge clk); #1;
            t++;
        end
        checks++;
        if (sb.size() != 0) begin
            failures++;
            $display("FAIL %s_timeout: got %0d pending required 0", name, sb.size());
            sb.delete();
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; run = 1'b0; restart = 1'b0; sample_strobe = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (gate !== 1'b0) begin failures++; $display("FAIL reset_gate: got %0b required 0", gate); end
        checks++;
        if (note_inc !== 7'd0) begin failures++; $display("FAIL reset_inc: got %0d required 0", note_inc); end
        checks++;
        if (melody_pos !== 5'd0) begin failures++; $display("FAIL reset_pos: got %0d required 0", melody_pos); end
        checks++;
        if (loop_done !== 1'b0) begin failures++; $display("FAIL reset_loop_done: got %0b required 0", loop_done); end
        rst_n = 1'b1;
        sample_strobe = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if (gate !== 1'b0) begin failures++; $display("FAIL idle_gate: got %0b required 0", gate); end
    endtask

    task automatic test_first_notes();
        sb.push_back(mk(0));
        sb.push_back(mk(1));
        mon_en = 1;
        run = 1'b1;
        @(negedge clk);
        checks++;
        if (gate !== 1'b1 || note_inc !== 7'd60) begin
            failures++;
            $display("FAIL run_latency: got gate=%0b inc=%0d required gate=1 inc=60", gate, note_inc);
        end
        drain("first_notes");
    endtask

    task automatic test_short_note();
        sb.push_back(mk(2));
        sb.push_back(mk(3));
        drain("short_note");
        checks++;
        if (melody_pos !== 5'd3 || note_inc !== 7'd50) begin
            failures++;
            $display("FAIL after_short: got pos=%0d inc=%0d required pos=3 inc=50", melody_pos, note_inc);
        end
    endtask

    task automatic test_pause();
        mon_en = 0;
        repeat (9) @(negedge clk);
        run = 1'b0;
        @(negedge clk);
        checks++;
        if (gate !== 1'b0 || melody_pos !== 5'd3 || note_inc !== 7'd50) begin
            failures++;
            $display("FAIL pause: got gate=%0b pos=%0d inc=%0d required gate=0 pos=3 inc=50",
                     gate, melody_pos, note_inc);
        end
        repeat (6) @(negedge clk);
        checks++;
        if (gate !== 1'b0 || melody_pos !== 5'd3) begin
            failures++;
            $display("FAIL pause_hold: got gate=%0b pos=%0d required gate=0 pos=3", gate, melody_pos);
        end
        sb.push_back(mk(3));
        sb.push_back(mk(4));
        mon_en = 1;
        run = 1'b1;
        @(negedge clk);
        checks++;
        if (gate !== 1'b1) begin failures++; $display("FAIL resume_latency: got gate=%0b required 1", gate); end
        drain("pause");
    endtask

    task automatic test_loop_wrap();
        int t0, ld0;
        for (int i = 5; i < 25; i++) sb.push_back(mk(i));
        sb.push_back(mk(0));
        drain("loop1");
        checks++;
        if (loop_done !== 1'b1 || melody_pos !== 5'd0 || note_inc !== 7'd60) begin
            failures++;
            $display("FAIL wrap: got ld=%0b pos=%0d inc=%0d required ld=1 pos=0 inc=60",
                     loop_done, melody_pos, note_inc);
        end
        t0 = cyc;
        ld0 = ld_cnt;
        for (int i = 1; i < 25; i++) sb.push_back(mk(i));
        sb.push_back(mk(0));
        drain("loop2");
        checks++;
        if (cyc - t0 !== 512) begin
            failures++;
            $display("FAIL loop_len: got %0d required 512", cyc - t0);
        end
        checks++;
        if (ld_cnt - ld0 !== 1 || loop_done !== 1'b1) begin
            failures++;
            $display("FAIL loop_done_pulses: got %0d now=%0b required 1 now=1", ld_cnt - ld0, loop_done);
        end
        @(negedge clk);
        checks++;
        if (loop_done !== 1'b0) begin failures++; $display("FAIL loop_done_width: got %0b required 0", loop_done); end
    endtask

    task automatic test_restart_wrap();
        int ld0, hi;
        mon_en = 0;
        repeat (510) @(negedge clk);
        ld0 = ld_cnt;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        checks++;
        if (melody_pos !== 5'd0 || loop_done !== 1'b0 || gate !== 1'b1 || note_inc !== 7'd60) begin
            failures++;
            $display("FAIL restart_run: got pos=%0d ld=%0b gate=%0b inc=%0d required pos=0 ld=0 gate=1 inc=60",
                     melody_pos, loop_done, gate, note_inc);
        end
        hi = 1;
        for (int i = 1; i < 512; i++) begin
            @(negedge clk);
            if (i <= 28 && gate === 1'b1) hi++;
        end
        checks++;
        if (ld_cnt !== ld0) begin failures++; $display("FAIL restart_no_loop_done: got %0d required %0d", ld_cnt, ld0); end
        checks++;
        if (hi !== 28) begin failures++; $display("FAIL restart_gate_len: got %0d required 28", hi); end
        ld0 = ld_cnt;
        run = 1'b0;
        restart = 1'b1;
        @(negedge clk);
        restart = 1'b0;
        checks++;
        if (melody_pos !== 5'd0 || loop_done !== 1'b0 || gate !== 1'b0) begin
            failures++;
            $display("FAIL restart_idle: got pos=%0d ld=%0b gate=%0b required pos=0 ld=0 gate=0",
                     melody_pos, loop_done, gate);
        end
        repeat (10) @(negedge clk);
        checks++;
        if (gate !== 1'b0 || melody_pos !== 5'd0 || ld_cnt !== ld0) begin
            failures++;
            $display("FAIL restart_idle_hold: got gate=%0b pos=%0d ld_pulses=%0d required gate=0 pos=0 ld_pulses=0",
                     gate, melody_pos, ld_cnt - ld0);
        end
    endtask

    task automatic test_async_reset();
        run = 1'b1;
        repeat (40) @(negedge clk);
        checks++;
        if (gate !== 1'b1 || melody_pos !== 5'd1) begin
            failures++;
            $display("FAIL pre_reset: got gate=%0b pos=%0d required gate=1 pos=1", gate, melody_pos);
        end
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (gate !== 1'b0) begin failures++; $display("FAIL async_gate: got %0b required 0", gate); end
        checks++;
        if (note_inc !== 7'd0) begin failures++; $display("FAIL async_inc: got %0d required 0", note_inc); end
        checks++;
        if (melody_pos !== 5'd0) begin failures++; $display("FAIL async_pos: got %0d required 0", melody_pos); end
        checks++;
        if (loop_done !== 1'b0) begin failures++; $display("FAIL async_loop_done: got %0b required 0", loop_done); end
    endtask

    initial begin
        test_reset();
        test_first_notes();
        test_short_note();
        test_pause();
        test_loop_wrap();
        test_restart_wrap();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
